// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg : state encoding and constants for the instruction loader
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          BYTES_PER_WORD = 4;

  localparam state_e      RST_STATE = ST_IDLE;
  localparam logic [31:0] RST_WORD  = 32'h0000_0000;
  localparam logic        RST_BIT   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/imem_loader_packer.sv
// ============================================================================
// byte_packer : shifts stream bytes into a big-endian 32-bit word
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic        complete_o,
  output logic [31:0] word_o
);

  // Only the three earlier bytes need storage; the fourth is taken straight
  // from the input so the word is available on the accepting edge.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= RST_WORD[23:0];
      cnt_q   <= 2'd0;
    end else if (clear_i) begin
      shift_q <= RST_WORD[23:0];
      cnt_q   <= 2'd0;
    end else if (shift_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign complete_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o     = {shift_q, byte_i};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : byte-stream instruction memory loader, holds the core meanwhile
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] BaseAddress,
  input  logic [15:0] WordCount,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrAddress,
  output logic [31:0] WrData,
  output logic        CpuHold,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  state_e      state_q;
  logic [31:0] base_q;
  logic [15:0] count_q;
  logic [15:0] idx_q;
  logic        ready_q;
  logic        wren_q;
  logic [31:0] wraddr_q;
  logic [31:0] wrdata_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        w_accept;
  logic        w_shift;
  logic        w_clear;
  logic        w_word_done;
  logic [31:0] w_word;
  logic [31:0] w_addr;
  logic [32:0] w_word_index;
  logic        w_overflow;
  logic [16:0] w_idx_inc;

  assign w_accept = ByteValid && ready_q;
  assign w_shift  = w_accept && (state_q == ST_RECV);
  assign w_clear  = Start && (state_q == ST_IDLE);

  byte_packer u_packer (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .clear_i    (w_clear),
    .shift_i    (w_shift),
    .byte_i     (ByteIn),
    .complete_o (w_word_done),
    .word_o     (w_word)
  );

  // Address wraps modulo 2^32; the range check is done in 33 bits so a
  // base near the top of the address space cannot alias back into range.
  assign w_addr       = base_q + {14'd0, idx_q, 2'b00};
  assign w_word_index = {3'd0, base_q[31:2]} + {17'd0, idx_q};
  assign w_overflow   = (w_word_index >= 33'(DEPTH));
  assign w_idx_inc    = {1'b0, idx_q} + 17'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= RST_STATE;
      base_q   <= RST_WORD;
      count_q  <= 16'd0;
      idx_q    <= 16'd0;
      ready_q  <= RST_BIT;
      wren_q   <= RST_BIT;
      wraddr_q <= RST_WORD;
      wrdata_q <= RST_WORD;
      busy_q   <= RST_BIT;
      done_q   <= RST_BIT;
      error_q  <= RST_BIT;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            base_q  <= {BaseAddress[31:2], 2'b00};
            count_q <= WordCount;
            idx_q   <= 16'd0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
            if (WordCount == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= ST_CHECK;
              ready_q <= 1'b1;
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= ST_RECV;
              ready_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_shift) csum_q <= csum_q ^ ByteIn;
`endif
          if (w_word_done) begin
            state_q  <= ST_WRITE;
            ready_q  <= 1'b0;
            wren_q   <= !w_overflow;
            wraddr_q <= w_addr;
            wrdata_q <= w_word;
            if (w_overflow) error_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          idx_q <= w_idx_inc[15:0];
          if (w_idx_inc < {1'b0, count_q}) begin
            state_q <= ST_RECV;
            ready_q <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= ST_CHECK;
            ready_q <= 1'b1;
`else
            state_q <= ST_DONE;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            ready_q <= 1'b0;
            if (ByteIn != csum_q) error_q <= 1'b1;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ByteReady = ready_q;
  assign WrEn      = wren_q;
  assign WrAddress = wraddr_q;
  assign WrData    = wrdata_q;
  assign Busy      = busy_q;
  assign CpuHold   = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : scoreboard bench for imem_loader (LOADER_CHECKSUM_EN aware)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [31:0] BaseAddress;
  logic [15:0] WordCount;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WrEn;
  logic [31:0] WrAddress;
  logic [31:0] WrData;
  logic        CpuHold;
  logic        Busy;
  logic        Done;
  logic        Error;

  imem_loader #(.DEPTH(512)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .BaseAddress (BaseAddress),
    .WordCount   (WordCount),
    .ByteIn      (ByteIn),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .WrEn        (WrEn),
    .WrAddress   (WrAddress),
    .WrData      (WrData),
    .CpuHold     (CpuHold),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [31:0] data_w[16];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", WrAddress, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", WrAddress, e[63:32]);
        chk("wr_data", WrData, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge Clk);
    ByteIn    = b;
    ByteValid = 1'b1;
    while (ByteReady !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", {31'd0, ByteReady}, 32'd1);
    @(posedge Clk);
    #1 ByteValid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input int n);
    @(negedge Clk);
    Start       = 1'b1;
    BaseAddress = base;
    WordCount   = 16'(n);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] base, input int i, input logic [31:0] w);
    logic [32:0] widx;
    logic [31:0] a;
    widx = {3'd0, base[31:2]} + 33'(i);
    a    = {base[31:2], 2'b00} + 32'(4 * i);
    if (widx < 33'd512) sb_q.push_back({a, w});
  endtask

  task automatic run_load(input logic [31:0] base, input int n, input int gap,
                          input bit bad_csum, input bit poke, input bit exp_err);
    logic [7:0] cs;
    logic [7:0] b;
    bit         exp_rdy;
    cs = 8'h00;
    pulse_start(base, n);
`ifdef LOADER_CHECKSUM_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = (n != 0);
`endif
    chk("busy_after_start", {31'd0, Busy}, 32'd1);
    chk("hold_after_start", {31'd0, CpuHold}, 32'd1);
    chk("ready_after_start", {31'd0, ByteReady}, {31'd0, exp_rdy});
    chk("error_cleared", {31'd0, Error}, 32'd0);
`ifndef LOADER_CHECKSUM_EN
    if (n == 0) begin
      chk("zero_done", {31'd0, Done}, 32'd1);
      @(negedge Clk);
      chk("zero_idle", {31'd0, Busy}, 32'd0);
      chk("zero_no_write", sb_q.size(), 32'd0);
      return;
    end
`endif
    for (int i = 0; i < n; i++) begin
      push_word(base, i, data_w[i]);
      for (int k = 0; k < 4; k++) begin
        b  = data_w[i][31 - 8 * k -: 8];
        cs = cs ^ b;
        if (gap > 0) repeat (gap) @(negedge Clk);
        send_byte(b);
        if (poke && i == 0 && k == 1) pulse_start(32'h0000_0100, 7);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs ^ {7'd0, bad_csum});
    @(negedge Clk);
`else
    @(negedge Clk);
    @(negedge Clk);
`endif
    chk("done_pulse", {31'd0, Done}, 32'd1);
    chk("error_flag", {31'd0, Error}, {31'd0, exp_err});
    @(negedge Clk);
    chk("done_one_cycle", {31'd0, Done}, 32'd0);
    chk("idle_busy", {31'd0, Busy}, 32'd0);
    chk("writes_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; BaseAddress = '0; WordCount = '0;
    ByteIn = '0; ByteValid = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_ready", {31'd0, ByteReady}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_wraddr", WrAddress, 32'd0);
    chk("rst_wrdata", WrData, 32'd0);
    chk("rst_error", {31'd0, Error}, 32'd0);
    Reset = 1'b0;

    // Basic load, back-to-back bytes
    data_w[0] = 32'h2008_0005; data_w[1] = 32'hAC09_0004;
    run_load(32'h0, 2, 0, 1'b0, 1'b0, 1'b0);
    // Same stream with 3-cycle gaps between bytes
    run_load(32'h0, 2, 3, 1'b0, 1'b0, 1'b0);
    // Second word falls past DEPTH
    data_w[0] = 32'h1111_2222; data_w[1] = 32'h3333_4444;
    run_load(32'h0000_07FC, 2, 0, 1'b0, 1'b0, 1'b1);
    // Unaligned base is forced to a word boundary; Start during load ignored
    data_w[0] = 32'hDEAD_BEEF; data_w[1] = 32'h0123_4567;
    run_load(32'h0000_0043, 2, 1, 1'b0, 1'b1, 1'b0);
    // Zero-count load
    run_load(32'h0000_0010, 0, 0, 1'b0, 1'b0, 1'b0);
    // Random words and gaps
    for (int i = 0; i < 5; i++) data_w[i] = $urandom;
    run_load(32'h0000_0100, 5, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);

    // Reset after 6 bytes of a 4-word load
    for (int i = 0; i < 4; i++) data_w[i] = 32'hA0B0_C0D0 + 32'(i);
    pulse_start(32'h0000_0040, 4);
    push_word(32'h0000_0040, 0, data_w[0]);
    for (int k = 0; k < 4; k++) send_byte(data_w[0][31 - 8 * k -: 8]);
    send_byte(data_w[1][31:24]);
    send_byte(data_w[1][23:16]);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hold", {31'd0, CpuHold}, 32'd0);
    chk("abort_ready", {31'd0, ByteReady}, 32'd0);
    chk("abort_wraddr", WrAddress, 32'd0);
    chk("abort_wrdata", WrData, 32'd0);
    chk("abort_word0_written", sb_q.size(), 32'd0);
    sb_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    data_w[0] = 32'h8C08_0000; data_w[1] = 32'h0000_0000;
    run_load(32'h0000_0040, 2, 0, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    data_w[0] = 32'h0102_0304;
    run_load(32'h0000_0020, 1, 0, 1'b0, 1'b0, 1'b0);
    run_load(32'h0000_0020, 1, 0, 1'b1, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
